// File: rtl/systolic_phase_seq.sv
// systolic_phase_seq: three-phase sequencer (weight load, activation stream,
// accumulator drain) for the systolic array. Each phase boundary is found by
// comparing the external enable counter's value against the phase length.
module systolic_phase_seq #(
  parameter int W_LEN = 128,
  parameter int S_LEN = 128,
  parameter int D_LEN = 255,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] count,
  output logic             cnt_en,
  output logic             w_load,
  output logic             x_valid,
  output logic             drain,
  output logic             busy,
  output logic             done,
  output logic [1:0]       phase
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Terminal count of each phase; a length of 256 gives 255 so count never wraps.
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_LEN - 1);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(S_LEN - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] last;
  logic             in_phase;
  logic             at_last;

  // State register; asynchronous reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Select the terminal count for the active phase.
  always_comb begin
    last     = '0;
    in_phase = 1'b0;
    case (state_q)
      S_LOAD_W: begin last = W_LAST; in_phase = 1'b1; end
      S_STREAM: begin last = S_LAST; in_phase = 1'b1; end
      S_DRAIN:  begin last = D_LAST; in_phase = 1'b1; end
      default:  begin last = '0;     in_phase = 1'b0; end
    endcase
    at_last = (count == last);
  end

  // Next-state logic; abort outranks both start and a phase-end advance.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start)   state_d = S_LOAD_W;
        S_LOAD_W: if (at_last) state_d = S_STREAM;
        S_STREAM: if (at_last) state_d = S_DRAIN;
        S_DRAIN:  if (at_last) state_d = S_DONE;
        S_DONE:                state_d = S_IDLE;
        default:               state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: strobes decode the state only; cnt_en also looks at count so the
  // counter clears in the last cycle of a phase and the next phase starts at 0.
  always_comb begin
    cnt_en  = in_phase && !abort && !at_last;
    w_load  = (state_q == S_LOAD_W);
    x_valid = (state_q == S_STREAM);
    drain   = (state_q == S_DRAIN);
    done    = (state_q == S_DONE);
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_LOAD_W: phase = 2'd1;
      S_STREAM: phase = 2'd2;
      S_DRAIN:  phase = 2'd3;
      default:  phase = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_systolic_phase_seq.sv
// Directed bench for systolic_phase_seq: three instances (4/3/5 lengths,
// default lengths, all-ones lengths), each driving its own enable counter.
module tb_systolic_phase_seq;

  logic clk;
  logic rst;
  int   ntests;
  int   nfail;

  logic       start_a, abort_a, cnt_en_a, w_load_a, x_valid_a, drain_a, busy_a, done_a;
  logic [1:0] phase_a;
  logic [7:0] count_a;
  logic       start_b, abort_b, cnt_en_b, w_load_b, x_valid_b, drain_b, busy_b, done_b;
  logic [1:0] phase_b;
  logic [7:0] count_b;
  logic       start_c, abort_c, cnt_en_c, w_load_c, x_valid_c, drain_c, busy_c, done_c;
  logic [1:0] phase_c;
  logic [7:0] count_c;

  systolic_phase_seq #(.W_LEN(4), .S_LEN(3), .D_LEN(5), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .count(count_a),
    .cnt_en(cnt_en_a), .w_load(w_load_a), .x_valid(x_valid_a), .drain(drain_a),
    .busy(busy_a), .done(done_a), .phase(phase_a));

  systolic_phase_seq u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .count(count_b),
    .cnt_en(cnt_en_b), .w_load(w_load_b), .x_valid(x_valid_b), .drain(drain_b),
    .busy(busy_b), .done(done_b), .phase(phase_b));

  systolic_phase_seq #(.W_LEN(1), .S_LEN(1), .D_LEN(1), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .count(count_c),
    .cnt_en(cnt_en_c), .w_load(w_load_c), .x_valid(x_valid_c), .drain(drain_c),
    .busy(busy_c), .done(done_c), .phase(phase_c));

  // Enable counters: increment while enabled, clear otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_a <= '0;
      count_b <= '0;
      count_c <= '0;
    end else begin
      count_a <= cnt_en_a ? count_a + 8'd1 : 8'd0;
      count_b <= cnt_en_b ? count_b + 8'd1 : 8'd0;
      count_c <= cnt_en_c ? count_c + 8'd1 : 8'd0;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full 4/3/5 sequence on instance A. LOAD_W 1-4, STREAM 5-7, DRAIN 8-12, DONE 13.
  task automatic run_basic(input string tag);
    logic [31:0] e_phase;
    logic [31:0] e_cnt;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      e_phase = (c >= 1 && c <= 4) ? 1 : (c >= 5 && c <= 7) ? 2 : (c >= 8 && c <= 12) ? 3 : 0;
      e_cnt   = (c >= 1 && c <= 4) ? c - 1 : (c >= 5 && c <= 7) ? c - 5 : (c >= 8 && c <= 12) ? c - 8 : 0;
      chk({tag, "_wload"},  w_load_a,  (c >= 1 && c <= 4));
      chk({tag, "_xvalid"}, x_valid_a, (c >= 5 && c <= 7));
      chk({tag, "_drain"},  drain_a,   (c >= 8 && c <= 12));
      chk({tag, "_done"},   done_a,    (c == 13));
      chk({tag, "_busy"},   busy_a,    (c <= 13));
      chk({tag, "_phase"},  phase_a,   e_phase);
      chk({tag, "_count"},  count_a,   e_cnt);
      chk({tag, "_cnten"},  cnt_en_a,  (c <= 12 && c != 4 && c != 7 && c != 12));
      tick();
    end
  endtask

  initial begin
    int nw, nx, nd, dc, ndone, nen;
    ntests  = 0;
    nfail   = 0;
    rst     = 1'b1;
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    start_c = 1'b0; abort_c = 1'b0;

    // Reset state
    #2;
    chk("rst_busy_a",  busy_a,   0);
    chk("rst_cnten_a", cnt_en_a, 0);
    chk("rst_phase_a", phase_a,  0);
    chk("rst_done_a",  done_a,   0);
    chk("rst_wload_a", w_load_a, 0);
    chk("rst_busy_b",  busy_b,   0);
    chk("rst_busy_c",  busy_c,   0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic sequence
    run_basic("basic");

    // Abort in STREAM at count=1 (cycle 6)
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5) tick();
    chk("ab_xvalid_pre", x_valid_a, 1);
    chk("ab_count_pre",  count_a,   1);
    abort_a = 1'b1;
    #1;
    chk("ab_cnten_forced", cnt_en_a, 0);
    tick();
    abort_a = 1'b0;
    chk("ab_busy",   busy_a,    0);
    chk("ab_phase",  phase_a,   0);
    chk("ab_xvalid", x_valid_a, 0);
    chk("ab_drain",  drain_a,   0);
    chk("ab_cnten",  cnt_en_a,  0);
    chk("ab_done",   done_a,    0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      ndone += int'(done_a) + int'(busy_a);
      tick();
    end
    chk("ab_no_done_after", ndone, 0);

    // start held high: no restart mid-sequence, next run from IDLE after DONE
    start_a = 1'b1;
    tick();
    repeat (4) tick();
    chk("hold_phase_c5", phase_a, 2);
    repeat (8) tick();
    chk("hold_done_c13", done_a, 1);
    tick();
    chk("hold_busy_c14", busy_a, 0);
    tick();
    chk("hold_wload_c15", w_load_a, 1);
    chk("hold_count_c15", count_a,  0);
    start_a = 1'b0;
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("hold_abort_idle", busy_a, 0);
    tick();

    // Asynchronous reset mid-DRAIN, then a fresh full sequence
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (9) tick();
    chk("ar_drain_pre", drain_a, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_drain", drain_a,  0);
    chk("ar_busy",  busy_a,   0);
    chk("ar_phase", phase_a,  0);
    chk("ar_cnten", cnt_en_a, 0);
    chk("ar_count", count_a,  0);
    #1;
    rst = 1'b0;
    tick();
    run_basic("after_rst");

    // Abort together with start in IDLE
    abort_a = 1'b1;
    start_a = 1'b1;
    tick();
    abort_a = 1'b0;
    start_a = 1'b0;
    chk("col_idle_busy",  busy_a,   0);
    chk("col_idle_wload", w_load_a, 0);

    // Abort coinciding with count==last in LOAD_W
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3) tick();
    chk("col_wload_c4", w_load_a, 1);
    chk("col_count_c4", count_a,  3);
    abort_a = 1'b1;
    #1;
    chk("col_cnten", cnt_en_a, 0);
    tick();
    abort_a = 1'b0;
    chk("col_xvalid", x_valid_a, 0);
    chk("col_busy",   busy_a,    0);
    chk("col_phase",  phase_a,   0);
    tick();
    chk("col_still_idle", busy_a, 0);

    // Default lengths: done in cycle 1+128+128+255 = 512
    nw = 0; nx = 0; nd = 0; dc = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 600 && dc == 0; c++) begin
      nw += int'(w_load_b);
      nx += int'(x_valid_b);
      nd += int'(drain_b);
      if (done_b) dc = c;
      tick();
    end
    chk("def_done_cycle", dc, 512);
    chk("def_wload_n",    nw, 128);
    chk("def_xvalid_n",   nx, 128);
    chk("def_drain_n",    nd, 255);
    chk("def_idle_after", busy_b, 0);

    // Length-1 phases
    nen = 0;
    start_c = 1'b1;
    #1;
    nen += int'(cnt_en_c);
    tick();
    start_c = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk("l1_wload",  w_load_c,  (c == 1));
      chk("l1_xvalid", x_valid_c, (c == 2));
      chk("l1_drain",  drain_c,   (c == 3));
      chk("l1_done",   done_c,    (c == 4));
      chk("l1_busy",   busy_c,    (c <= 4));
      nen += int'(cnt_en_c);
      tick();
    end
    chk("l1_cnten_never", nen, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
